fp_argmax_classifier: RTL and testbench
=======================================

Name: fp_argmax_classifier

Overview:
- Downstream of fp_dot_product. Consumes its stream of per-class scores, one WIDTH-bit IEEE-754 single per valid cycle, NUM_CLASSES scores per pixel, class 0 first.
- Tracks the running maximum and emits the winning class index per pixel.
- The output is held in a one-entry result register with a valid/ready handshake toward the label writer.

Parameters:
WIDTH, 32, float width; only 32 (IEEE-754 single) supported
NUM_CLASSES, 7, scores per pixel; must be >= 2
IDX_WIDTH, $clog2(NUM_CLASSES), class index width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
flush  in  1  synchronous; abandons the partially accumulated pixel
in_data  in  WIDTH  score from fp_dot_product out
in_valid  in  1  score valid (fp_dot_product valid); no backpressure upstream
out_idx  out  IDX_WIDTH  winning class index
out_valid  out  1  result held
out_ready  in  1  downstream accepts result when out_valid && out_ready
overflow  out  1  sticky; a pixel result was lost
busy  out  1  partial pixel in progress (cls_cnt != 0)

Behaviour:
- Reset (rst low, async): cls_cnt=0, best_val=0, best_idx=0, out_idx=0, out_valid=0, overflow=0, busy=0.
- Compare rule (fp_gt): a > b on sign-magnitude ordering.
  - +0 and -0 are equal.
  - NaN (exp=0xFF, mant!=0) never compares greater, and any non-NaN compares greater than a NaN best.
  - +/-Inf are ordered normally.
  - Denormals are compared exactly, not flushed.
- Accumulation FSM, two states:
  - IDLE (cls_cnt==0): on in_valid, best_val<=in_data, best_idx<=0, cls_cnt<=1 → ACCUM.
  - ACCUM: on in_valid, if fp_gt(in_data, best_val) then best_val<=in_data, best_idx<=cls_cnt. cls_cnt increments.
  - When the accepted score has cls_cnt==NUM_CLASSES-1, cls_cnt wraps to 0 → IDLE and the pixel completes.
- Ties: strict greater-than, so the lowest index wins.
- Completion: the final index includes the comparison against the last score and is written to out_idx. out_valid is 1 on the cycle after the last in_valid (latency 1).
- Result register:
  - out_valid stays high and out_idx stays stable until a handshake.
  - A handshake with no simultaneous completion clears out_valid next cycle.
  - Completion with out_valid=0: load the result.
  - Completion with out_valid=1 and out_ready=1 in the same cycle: load the new result, out_valid stays 1.
  - Completion with out_valid=1 and out_ready=0: the new result is dropped, the old one is kept, overflow<=1 (sticky until reset).
- flush: has priority over in_valid in the same cycle. cls_cnt<=0, and the partial best is discarded. The result register and overflow are untouched.
- In IDLE with in_valid low nothing changes. Gaps between scores of one pixel are allowed.
- Async reset mid-pixel: everything returns to reset values immediately. The next in_valid is treated as class 0.

Optional Feature:
FP_ARGMAX_SCORE_OUT_EN
- Defined: adds output port out_score [WIDTH]. It carries the winning score, registered alongside out_idx with identical valid/hold/drop rules; reset value 0.
- Undefined: the port and its register are absent. The best_val tracking register remains, since it is needed for comparison.

Decomposition:
- Shared package fp_pkg holds:
  - the float field constants FP_EXP_W=8, FP_MANT_W=23, FP_EXP_ALL1;
  - a packed struct fp32_t {sign, exp, mant};
  - the is_nan function.
- Sub-module fp_gt: purely combinational greater-than with the compare rules above; inputs a, b; output gt. It is reused by later stages.

Test Plan:
- Scores [0.5, 2.0, -1.0, 3.5, 3.5, 0.0, 1.0], out_ready=1 → out_idx=3 one cycle after the 7th score, out_valid high exactly one cycle.
- All negative [-3, -1, -2, -5, -4, -7, -6] → out_idx=1. Then [-0.0, +0.0, 0, 0, 0, 0, 0] → out_idx=0, tie kept at the lowest index.
- NaN at class 0 (0x7FC00000), then [1.0 ×6] → out_idx=1. All seven NaN → out_idx=0.
- out_ready=0, two pixels streamed back-to-back → first result held stable, overflow=1 after the second completes, out_idx unchanged. Then out_ready=1 → out_valid clears next cycle.
- Completion in the same cycle as an out_ready handshake → out_valid stays 1 and out_idx shows the new pixel; overflow stays 0.
- 3 scores then flush (also rst pulsed low mid-pixel in a second run), then a full 7-score pixel with max at class 6 → out_idx=6, busy=0 after completion. Partial data is not used.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field definitions and helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;
    localparam logic [FP_EXP_W-1:0] FP_EXP_ALL1 = '1;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp32_t;

    // Accumulation state of the argmax classifier.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } argmax_state_t;

    function automatic logic is_nan(input fp32_t f);
        return (f.exp == FP_EXP_ALL1) && (f.mant != '0);
    endfunction

endpackage

// File: rtl/fp_gt.sv
// Combinational IEEE-754 single greater-than (a > b) on sign-magnitude ordering.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a, b - operands; gt - 1 when a is strictly greater than b.
// +0 == -0, a NaN never wins, any non-NaN beats a NaN, Inf ordered normally,
// denormals compared exactly.
module fp_gt
    import fp_pkg::*;
(
    input  logic [FP_EXP_W+FP_MANT_W:0] a,
    input  logic [FP_EXP_W+FP_MANT_W:0] b,
    output logic                        gt
);

    fp32_t fa;
    fp32_t fb;
    logic [FP_EXP_W+FP_MANT_W-1:0] mag_a;
    logic [FP_EXP_W+FP_MANT_W-1:0] mag_b;

    assign fa    = a;
    assign fb    = b;
    assign mag_a = {fa.exp, fa.mant};
    assign mag_b = {fb.exp, fb.mant};

    always_comb begin
        gt = 1'b0;
        if (is_nan(fa)) begin
            gt = 1'b0;
        end else if (is_nan(fb)) begin
            gt = 1'b1;
        end else if ((mag_a == '0) && (mag_b == '0)) begin
            // signed zeros are equal
            gt = 1'b0;
        end else if (fa.sign != fb.sign) begin
            gt = ~fa.sign;
        end else if (!fa.sign) begin
            gt = (mag_a > mag_b);
        end else begin
            // both negative: smaller magnitude is the larger value
            gt = (mag_a < mag_b);
        end
    end

endmodule

// File: rtl/fp_argmax_classifier.sv
// Per-pixel argmax over NUM_CLASSES float scores; emits the winning class index.
// Latency: result valid 1 cycle after the last score of a pixel.
// Backpressure: one-entry result register; a completion while a result is held
//   and not accepted is dropped and sets sticky overflow. Upstream is never stalled.
// Ports: clk, rst (async active-low), flush (abandons partial pixel),
//   in_data/in_valid (score stream), out_idx/out_valid/out_ready (result),
//   overflow (sticky lost result), busy (pixel partially accumulated).
// Optional: FP_ARGMAX_SCORE_OUT_EN adds out_score carrying the winning score.
module fp_argmax_classifier
    import fp_pkg::*;
#(
    parameter int WIDTH       = 32,   // only 32 supported
    parameter int NUM_CLASSES = 7,    // must be >= 2
    parameter int IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic [IDX_WIDTH-1:0] out_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef FP_ARGMAX_SCORE_OUT_EN
    output logic [WIDTH-1:0]     out_score,
`endif
    output logic                 overflow,
    output logic                 busy
);

    localparam logic [IDX_WIDTH-1:0] LAST_CLS = IDX_WIDTH'(NUM_CLASSES - 1);

    argmax_state_t        state, state_nxt;
    logic [IDX_WIDTH-1:0] cls_cnt, cls_cnt_nxt;
    logic [WIDTH-1:0]     best_val, best_val_nxt;
    logic [IDX_WIDTH-1:0] best_idx, best_idx_nxt;
    logic [IDX_WIDTH-1:0] out_idx_nxt;
    logic                 out_valid_nxt;
    logic                 overflow_nxt;
    logic                 score_gt;
    logic                 done;
    logic                 load_result;
`ifdef FP_ARGMAX_SCORE_OUT_EN
    logic [WIDTH-1:0]     out_score_nxt;
`endif

    fp_gt u_fp_gt (
        .a  (in_data),
        .b  (best_val),
        .gt (score_gt)
    );

    // Accumulation: next-state and running best.
    always_comb begin
        state_nxt    = state;
        cls_cnt_nxt  = cls_cnt;
        best_val_nxt = best_val;
        best_idx_nxt = best_idx;
        done         = 1'b0;
        if (flush) begin
            // partial best is left stale; IDLE reloads it on the next score
            state_nxt   = ST_IDLE;
            cls_cnt_nxt = '0;
        end else if (in_valid) begin
            case (state)
                ST_IDLE: begin
                    best_val_nxt = in_data;
                    best_idx_nxt = '0;
                    cls_cnt_nxt  = IDX_WIDTH'(1);
                    state_nxt    = ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (score_gt) begin
                        best_val_nxt = in_data;
                        best_idx_nxt = cls_cnt;
                    end
                    if (cls_cnt == LAST_CLS) begin
                        cls_cnt_nxt = '0;
                        state_nxt   = ST_IDLE;
                        done        = 1'b1;
                    end else begin
                        cls_cnt_nxt = cls_cnt + IDX_WIDTH'(1);
                    end
                end
                default: begin
                    state_nxt   = ST_IDLE;
                    cls_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Result register: load when empty or being drained this cycle, else drop.
    assign load_result = done && (!out_valid || out_ready);

    always_comb begin
        out_valid_nxt = out_valid;
        out_idx_nxt   = out_idx;
        overflow_nxt  = overflow;
`ifdef FP_ARGMAX_SCORE_OUT_EN
        out_score_nxt = out_score;
`endif
        if (load_result) begin
            out_valid_nxt = 1'b1;
            out_idx_nxt   = best_idx_nxt;
`ifdef FP_ARGMAX_SCORE_OUT_EN
            out_score_nxt = best_val_nxt;
`endif
        end else if (done) begin
            overflow_nxt = 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cls_cnt   <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cls_cnt   <= cls_cnt_nxt;
            best_val  <= best_val_nxt;
            best_idx  <= best_idx_nxt;
            out_idx   <= out_idx_nxt;
            out_valid <= out_valid_nxt;
            overflow  <= overflow_nxt;
        end
    end

`ifdef FP_ARGMAX_SCORE_OUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_score <= '0;
        end else begin
            out_score <= out_score_nxt;
        end
    end
`endif

    assign busy = (cls_cnt != '0);

endmodule

// File: tb/tb_fp_argmax_classifier.sv
// Self-checking bench for fp_argmax_classifier: directed scenarios plus
// randomized pixels checked against a list-level argmax reference model.
module tb_fp_argmax_classifier;

    localparam int NC = 7;
    localparam int IW = $clog2(NC);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [31:0]   in_data;
    logic          in_valid;
    logic [IW-1:0] out_idx;
    logic          out_valid;
    logic          out_ready;
    logic          overflow;
    logic          busy;
`ifdef FP_ARGMAX_SCORE_OUT_EN
    logic [31:0]   out_score;
`endif

    fp_argmax_classifier #(.WIDTH(32), .NUM_CLASSES(NC)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FP_ARGMAX_SCORE_OUT_EN
        .out_score (out_score),
`endif
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] pix [NC];
    bit          ready_last;
    bit          gaps;

    // ---------------- reference model ----------------
    function automatic bit m_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Real-number ordering of a non-NaN float as a signed integer.
    function automatic longint m_key(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    // First index of the maximum non-NaN score; 0 when every score is NaN.
    function automatic int ref_argmax();
        int     best;
        longint bk;
        best = -1;
        bk   = 0;
        for (int i = 0; i < NC; i++) begin
            if (!m_is_nan(pix[i])) begin
                if (best < 0 || m_key(pix[i]) > bk) begin
                    best = i;
                    bk   = m_key(pix[i]);
                end
            end
        end
        return (best < 0) ? 0 : best;
    endfunction

    function automatic logic [31:0] rand_score();
        logic [7:0]  exps  [6];
        logic [22:0] mants [4];
        exps  = '{8'd0, 8'd1, 8'd126, 8'd127, 8'd254, 8'd255};
        mants = '{23'd0, 23'd1, 23'h400000, 23'h7FFFFF};
        if ($urandom_range(0, 3) == 0) return $urandom;
        return {1'($urandom_range(0, 1)), exps[$urandom_range(0, 5)],
                mants[$urandom_range(0, 3)]};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_scores(input int from, input int to);
        for (int i = from; i < to; i++) begin
            if (i == NC - 1 && ready_last) out_ready = 1'b1;
            in_valid = 1'b1;
            in_data  = pix[i];
            tick();
            in_valid = 1'b0;
            if (gaps && i != NC - 1) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic set_ascending();
        pix = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                32'h40A00000, 32'h40C00000, 32'h40E00000};
    endtask

    task automatic set_basic();
        pix = '{32'h3F000000, 32'h40000000, 32'hBF800000, 32'h40600000,
                32'h40600000, 32'h00000000, 32'h3F800000};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1; ready_last = 1'b0; gaps = 1'b0;
        repeat (3) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        total++; if (out_idx !== '0) begin bad++; $display("FAIL reset_idx got=%0d want=0", out_idx); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b want=0", overflow); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        set_basic();
        drive_scores(0, NC - 1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0b want=0", out_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0b want=1", busy); end
        drive_scores(NC - 1, NC);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b want=1", out_valid); end
        total++; if (out_idx !== IW'(3)) begin bad++; $display("FAIL basic_idx got=%0d want=3", out_idx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%0b want=0", busy); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%0b want=0", out_valid); end
    endtask

    task automatic test_negative();
        pix = '{32'hC0400000, 32'hBF800000, 32'hC0000000, 32'hC0A00000,
                32'hC0800000, 32'hC0E00000, 32'hC0C00000};
        drive_scores(0, NC);
        total++; if (out_valid !== 1'b1 || out_idx !== IW'(1)) begin
            bad++; $display("FAIL neg_idx got=%0d/%0b want=1/1", out_idx, out_valid); end
        tick();
        pix = '{32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000,
                32'h00000000, 32'h00000000, 32'h00000000};
        drive_scores(0, NC);
        total++; if (out_valid !== 1'b1 || out_idx !== IW'(0)) begin
            bad++; $display("FAIL zero_tie_idx got=%0d/%0b want=0/1", out_idx, out_valid); end
        tick();
    endtask

    task automatic test_nan();
        pix = '{32'h7FC00000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                32'h3F800000, 32'h3F800000, 32'h3F800000};
        drive_scores(0, NC);
        total++; if (out_valid !== 1'b1 || out_idx !== IW'(1)) begin
            bad++; $display("FAIL nan_first_idx got=%0d/%0b want=1/1", out_idx, out_valid); end
        tick();
        for (int i = 0; i < NC; i++) pix[i] = 32'h7FC00000 | i;
        drive_scores(0, NC);
        total++; if (out_valid !== 1'b1 || out_idx !== IW'(0)) begin
            bad++; $display("FAIL all_nan_idx got=%0d/%0b want=0/1", out_idx, out_valid); end
        tick();
    endtask

    // Partial pixel abandoned by flush (kind=0) or by async reset (kind=1).
    task automatic test_abandon(input int kind);
        for (int i = 0; i < NC; i++) pix[i] = 32'h7F000000;
        drive_scores(0, 3);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abandon%0d_busy_pre got=%0b want=1", kind, busy); end
        if (kind == 0) begin
            // flush wins over a simultaneous score
            flush = 1'b1; in_valid = 1'b1; in_data = 32'h7F000000;
            tick();
            flush = 1'b0; in_valid = 1'b0;
        end else begin
            #2 rst = 1'b0;
            #1;
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%0b want=0", busy); end
            #2 rst = 1'b1;
            tick();
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abandon%0d_busy got=%0b want=0", kind, busy); end
        set_ascending();
        drive_scores(0, NC - 1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abandon%0d_early got=%0b want=0", kind, out_valid); end
        drive_scores(NC - 1, NC);
        total++; if (out_valid !== 1'b1 || out_idx !== IW'(6)) begin
            bad++; $display("FAIL abandon%0d_idx got=%0d/%0b want=6/1", kind, out_idx, out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abandon%0d_busy_end got=%0b want=0", kind, busy); end
        tick();
    endtask

    task automatic test_same_cycle();
        out_ready = 1'b0;
        set_basic();
        drive_scores(0, NC);
        total++; if (out_valid !== 1'b1 || out_idx !== IW'(3)) begin
            bad++; $display("FAIL same_first got=%0d/%0b want=3/1", out_idx, out_valid); end
        set_ascending();
        ready_last = 1'b1;
        drive_scores(0, NC);
        ready_last = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL same_valid got=%0b want=1", out_valid); end
        total++; if (out_idx !== IW'(6)) begin bad++; $display("FAIL same_idx got=%0d want=6", out_idx); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL same_overflow got=%0b want=0", overflow); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL same_clear got=%0b want=0", out_valid); end
    endtask

    task automatic test_random();
        int exp_idx;
        out_ready = 1'b1;
        gaps = 1'b1;
        for (int p = 0; p < 24; p++) begin
            for (int i = 0; i < NC; i++) pix[i] = rand_score();
            exp_idx = ref_argmax();
            drive_scores(0, NC);
            total++; if (out_valid !== 1'b1 || out_idx !== IW'(exp_idx)) begin
                bad++; $display("FAIL rand_idx p=%0d got=%0d/%0b want=%0d/1", p, out_idx, out_valid, exp_idx); end
            tick();
        end
        gaps = 1'b0;
    endtask

    task automatic test_back_to_back_overflow();
        out_ready = 1'b0;
        set_basic();
        drive_scores(0, NC);
        total++; if (out_valid !== 1'b1 || out_idx !== IW'(3)) begin
            bad++; $display("FAIL ovf_first got=%0d/%0b want=3/1", out_idx, out_valid); end
        set_ascending();
        drive_scores(0, NC);
        total++; if (out_idx !== IW'(3)) begin bad++; $display("FAIL ovf_held_idx got=%0d want=3", out_idx); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovf_held_valid got=%0b want=1", out_valid); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", overflow); end
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain got=%0b want=0", out_valid); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b want=1", overflow); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_nan();
        test_abandon(0);
        test_abandon(1);
        test_same_cycle();
        test_random();
        test_back_to_back_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
